// File: rtl/rect_fill_sched.sv
// rtl/rect_fill_sched.sv - clipped rectangle fill scheduler with interleaved single-pixel port
// Drives a VGA adapter write port one pixel per cycle; px requests get one slot per row boundary.
module rect_fill_sched #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x0,
  input  logic [7:0] y0,
  input  logic [7:0] w,
  input  logic [7:0] h,
  input  logic [2:0] fill_color,
  output logic       busy,
  output logic       done,
  input  logic       px_req,
  input  logic [7:0] px_x,
  input  logic [7:0] px_y,
  input  logic [2:0] px_color,
  output logic       px_ack,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [2:0] color_out,
  output logic       plot
);

  typedef enum logic [1:0] {IDLE, FILL, PXSLOT, DONE} state_t;

  localparam logic [8:0] SW9 = 9'(SCREEN_W);
  localparam logic [8:0] SH9 = 9'(SCREEN_H);

  state_t     state;
  logic [7:0] rx0;
  logic [7:0] cx;
  logic [7:0] cy;
  logic [8:0] xe;
  logic [8:0] ye;
  logic [2:0] col;

  logic [8:0] sum_x;
  logic [8:0] sum_y;
  logic [8:0] clip_xe;
  logic [8:0] clip_ye;
  logic [8:0] nx;
  logic [8:0] ny;
  logic       empty;
  logic       px_in;
  logic       row_more;
  logic       last_row;

  // End bounds are exclusive and kept 9 bits wide so x0+w never wraps before clipping.
  assign sum_x    = {1'b0, x0} + {1'b0, w};
  assign sum_y    = {1'b0, y0} + {1'b0, h};
  assign clip_xe  = (sum_x < SW9) ? sum_x : SW9;
  assign clip_ye  = (sum_y < SH9) ? sum_y : SH9;
  assign empty    = (w == 8'd0) || (h == 8'd0) ||
                    ({1'b0, x0} >= SW9) || ({1'b0, y0} >= SH9);
  assign px_in    = ({1'b0, px_x} < SW9) && ({1'b0, px_y} < SH9);
  assign nx       = {1'b0, cx} + 9'd1;
  assign ny       = {1'b0, cy} + 9'd1;
  assign row_more = nx < xe;
  assign last_row = ny >= ye;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      px_ack    <= 1'b0;
      plot      <= 1'b0;
      x         <= 8'd0;
      y         <= 8'd0;
      color_out <= 3'd0;
      rx0       <= 8'd0;
      cx        <= 8'd0;
      cy        <= 8'd0;
      xe        <= 9'd0;
      ye        <= 9'd0;
      col       <= 3'd0;
    end else begin
      plot   <= 1'b0;
      done   <= 1'b0;
      px_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rx0 <= x0;
            cx  <= x0;
            cy  <= y0;
            xe  <= clip_xe;
            ye  <= clip_ye;
            col <= fill_color;
            if (empty) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state     <= FILL;
              busy      <= 1'b1;
              plot      <= 1'b1;
              x         <= x0;
              y         <= y0;
              color_out <= fill_color;
            end
          end else if (px_req) begin
            px_ack <= 1'b1;
            if (px_in) begin
              plot      <= 1'b1;
              x         <= px_x;
              y         <= px_y;
              color_out <= px_color;
            end
          end
        end
        FILL: begin
          if (row_more) begin
            cx        <= nx[7:0];
            plot      <= 1'b1;
            x         <= nx[7:0];
            y         <= cy;
            color_out <= col;
          end else if (last_row) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (px_req) begin
            // Row counters stay put; the slot resumes at the start of the next row.
            state  <= PXSLOT;
            px_ack <= 1'b1;
            if (px_in) begin
              plot      <= 1'b1;
              x         <= px_x;
              y         <= px_y;
              color_out <= px_color;
            end
          end else begin
            cx        <= rx0;
            cy        <= ny[7:0];
            plot      <= 1'b1;
            x         <= rx0;
            y         <= ny[7:0];
            color_out <= col;
          end
        end
        PXSLOT: begin
          state     <= FILL;
          cx        <= rx0;
          cy        <= ny[7:0];
          plot      <= 1'b1;
          x         <= rx0;
          y         <= ny[7:0];
          color_out <= col;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_sched.sv
// tb/tb_rect_fill_sched.sv - self-checking bench for rect_fill_sched against a pixel-list model
module tb_rect_fill_sched;
  localparam int SW = 160;
  localparam int SH = 120;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] x0, y0, w, h;
  logic [2:0] fill_color;
  logic       busy, done;
  logic       px_req;
  logic [7:0] px_x, px_y;
  logic [2:0] px_color;
  logic       px_ack;
  logic [7:0] x, y;
  logic [2:0] color_out;
  logic       plot;

  always #5 clk = ~clk;

  rect_fill_sched #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .w(w), .h(h), .fill_color(fill_color),
    .busy(busy), .done(done),
    .px_req(px_req), .px_x(px_x), .px_y(px_y), .px_color(px_color), .px_ack(px_ack),
    .x(x), .y(y), .color_out(color_out), .plot(plot)
  );

  typedef struct packed {
    logic [7:0] px;
    logic [7:0] py;
    logic [2:0] pc;
  } pix_t;

  int   checks = 0;
  int   errors = 0;
  pix_t exp_q[$];
  pix_t obs_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Expected plot list: clipped raster rows, one pending px request slotted after the first non-final row.
  task automatic model(input int ax, input int ay, input int aw, input int ah, input int acol,
                       input bit pend, input int qx, input int qy, input int qc,
                       output int lat, output int slots, output bit left);
    int xe, ye, n;
    exp_q.delete();
    slots = 0;
    n     = 0;
    left  = pend;
    xe = (ax + aw < SW) ? ax + aw : SW;
    ye = (ay + ah < SH) ? ay + ah : SH;
    if (!(aw == 0 || ah == 0 || ax >= SW || ay >= SH)) begin
      for (int yy = ay; yy < ye; yy++) begin
        for (int xx = ax; xx < xe; xx++) begin
          exp_q.push_back(pix_t'{8'(xx), 8'(yy), 3'(acol)});
          n++;
        end
        if (yy < ye - 1 && left) begin
          slots++;
          left = 1'b0;
          if (qx < SW && qy < SH) exp_q.push_back(pix_t'{8'(qx), 8'(qy), 3'(qc)});
        end
      end
    end
    lat = n + slots + 1;
  endtask

  task automatic run_fill(input string tag, input int ax, input int ay, input int aw, input int ah,
                          input int acol, input bit pend, input int qx, input int qy, input int qc);
    int lat, slots, n_ack, done_cyc, busy_low, ack_run, max_run;
    bit left;
    model(ax, ay, aw, ah, acol, pend, qx, qy, qc, lat, slots, left);
    obs_q.delete();
    n_ack = 0; done_cyc = -1; busy_low = 0; ack_run = 0; max_run = 0;
    @(negedge clk);
    start = 1'b1;
    x0 = 8'(ax); y0 = 8'(ay); w = 8'(aw); h = 8'(ah); fill_color = 3'(acol);
    px_req = pend; px_x = 8'(qx); px_y = 8'(qy); px_color = 3'(qc);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      if (plot) obs_q.push_back(pix_t'{x, y, color_out});
      if (px_ack) begin
        n_ack++;
        ack_run++;
        px_req = 1'b0;
      end else begin
        ack_run = 0;
      end
      if (ack_run > max_run) max_run = ack_run;
      if (done) begin
        done_cyc = cyc;
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        break;
      end
      if (!busy) busy_low++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(done_cyc), 32'(lat));
    check({tag, "_acks"}, 32'(n_ack), 32'(slots));
    check({tag, "_ack_width_ok"}, 32'(max_run <= 1), 32'd1);
    check({tag, "_busy_low_cycles"}, 32'(busy_low), 32'd0);
    check({tag, "_plot_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_pixel"}, 32'(obs_q[i]), 32'(exp_q[i]));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_idle_quiet"}, 32'({busy, plot, px_ack}), 32'd0);
    if (left) begin
      @(negedge clk);
      check({tag, "_late_ack"}, 32'(px_ack), 32'd1);
      check({tag, "_late_plot"}, 32'(plot), 32'(qx < SW && qy < SH));
      if (qx < SW && qy < SH)
        check({tag, "_late_pixel"}, 32'(pix_t'{x, y, color_out}), 32'(pix_t'{8'(qx), 8'(qy), 3'(qc)}));
      px_req = 1'b0;
      @(negedge clk);
      check({tag, "_late_ack_end"}, 32'(px_ack), 32'd0);
    end
    px_req = 1'b0;
  endtask

  int   bx[5] = '{3, 159, 160, 20, 10};
  int   by[5] = '{4, 119, 10, 119, 120};
  int   bc[5] = '{1, 7, 2, 4, 6};
  int   prev_x, prev_y, nplots, ndones;
  bit   inr;

  initial begin
    reset = 1'b1; start = 1'b0; x0 = 8'd0; y0 = 8'd0; w = 8'd0; h = 8'd0; fill_color = 3'd0;
    px_req = 1'b0; px_x = 8'd0; px_y = 8'd0; px_color = 3'd0;
    #12;
    check("reset_outputs", 32'({plot, busy, done, px_ack}), 32'd0);
    check("reset_xyc", 32'({x, y, color_out}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_fill("basic_3x2", 10, 20, 3, 2, 5, 1'b0, 0, 0, 0);
    run_fill("clip_corner", 158, 119, 5, 4, 6, 1'b0, 0, 0, 0);
    run_fill("empty_w0", 30, 30, 0, 5, 1, 1'b0, 0, 0, 0);
    run_fill("empty_x200", 200, 10, 4, 4, 1, 1'b0, 0, 0, 0);
    run_fill("px_interleave", 0, 0, 2, 3, 3, 1'b1, 50, 50, 2);
    run_fill("start_wins_h1", 40, 40, 4, 1, 7, 1'b1, 60, 61, 4);
    run_fill("px_oor_slot", 5, 5, 3, 3, 2, 1'b1, 170, 5, 1);

    // Back-to-back px requests from idle, one acked per cycle; out-of-range ones leave x/y alone.
    prev_x = 0; prev_y = 0;
    @(negedge clk);
    px_req = 1'b1; px_x = 8'(bx[0]); px_y = 8'(by[0]); px_color = 3'(bc[0]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      inr = (bx[i] < SW) && (by[i] < SH);
      check("burst_ack", 32'(px_ack), 32'd1);
      check("burst_plot", 32'(plot), 32'(inr));
      if (inr) begin
        prev_x = bx[i]; prev_y = by[i];
        check("burst_pixel", 32'(pix_t'{x, y, color_out}), 32'(pix_t'{8'(bx[i]), 8'(by[i]), 3'(bc[i])}));
      end else begin
        check("burst_hold_xy", 32'({x, y}), 32'({8'(prev_x), 8'(prev_y)}));
      end
      if (i < 4) begin
        px_x = 8'(bx[i+1]); px_y = 8'(by[i+1]); px_color = 3'(bc[i+1]);
      end else begin
        px_req = 1'b0;
      end
    end
    @(negedge clk);
    check("burst_end", 32'({px_ack, plot}), 32'd0);

    for (int k = 0; k < 25; k++) begin
      int rx, ry, rw, rh, rc, qx, qy, qc;
      bit pend;
      rx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 170)) : int'($urandom_range(0, 150));
      ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(112, 125)) : int'($urandom_range(0, 112));
      rw = $urandom_range(0, 12);
      rh = $urandom_range(0, 8);
      rc = $urandom_range(0, 7);
      pend = 1'($urandom_range(0, 1));
      qx = $urandom_range(0, 175);
      qy = $urandom_range(0, 130);
      qc = $urandom_range(0, 7);
      run_fill("random", rx, ry, rw, rh, rc, pend, qx, qy, qc);
    end

    // Abort a 10x10 fill at its third pixel.
    @(negedge clk);
    start = 1'b1; x0 = 8'd5; y0 = 8'd5; w = 8'd10; h = 8'd10; fill_color = 3'd3;
    @(negedge clk);
    start = 1'b0;
    nplots = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (plot) nplots++;
      if (nplots == 3) break;
      @(negedge clk);
    end
    check("abort_reached_third", 32'(nplots), 32'd3);
    #1 reset = 1'b1;
    #1;
    check("abort_async_ctrl", 32'({plot, busy, done, px_ack}), 32'd0);
    check("abort_async_xyc", 32'({x, y, color_out}), 32'd0);
    #1 reset = 1'b0;
    nplots = 0; ndones = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (plot) nplots++;
      if (done) ndones++;
    end
    check("abort_no_done", 32'(ndones), 32'd0);
    check("abort_no_plot", 32'(nplots), 32'd0);
    run_fill("after_abort", 1, 2, 4, 3, 6, 1'b1, 7, 8, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
